bnn_conv_multi: RTL

BNN_CONV_MULTI -- requirements
Module: bnn_conv_multi

---
 rtl/bnn_conv_multi.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bnn_conv_multi.sv
// ============================================================================
// Module   : bnn_conv_multi
// Function : Binary 3x3 convolution over a stream of packed images with up to
//            MAX_K XNOR-popcount kernels. Optional macro BNN_THRESH_EN takes
//            per-kernel thresholds from the weight words (else fixed at 5).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bnn_conv_multi #(
    parameter int MAX_DIM = 16,
    parameter int MAX_K   = 4
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable,
    output logic [11:0] dut_wmem_read_address,
    input  logic [15:0] wmem_dut_read_data
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LDW  = 3'd1;
    localparam logic [2:0] c_HDR  = 3'd2;
    localparam logic [2:0] c_FILL = 3'd3;
    localparam logic [2:0] c_OUT  = 3'd4;
    localparam logic [2:0] c_NEXT = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [1:0]         r_ph;
    logic [3:0]         r_widx;
    logic [3:0]         r_kcnt;
    logic [2:0]         r_kidx;
    logic [8:0]         r_kern [MAX_K];
    logic [4:0]         r_n;
    logic [4:0]         r_nrows;
    logic [4:0]         r_out_row;
    logic [11:0]        r_img_base;
    logic [11:0]        r_saddr;
    logic [11:0]        r_waddr;
    logic [11:0]        r_oaddr;
    logic [MAX_DIM-1:0] r_row0;
    logic [MAX_DIM-1:0] r_row1;
    logic [MAX_DIM-1:0] r_row2;
`ifdef BNN_THRESH_EN
    logic [3:0]         r_thr [MAX_K];
`endif

    logic               w_rdy;
    logic [3:0]         w_kclamp;
    logic               w_hdr_ok;
    logic               w_ldw_done;
    logic               w_last_row;
    logic               w_more_k;
    logic               w_read_state;
    logic [8:0]         w_kern;
    logic [3:0]         w_thr;
    logic [MAX_DIM-3:0] w_pix;
    logic [15:0]        w_row_bits;

    // Memories return data one cycle after the registered address, so each read
    // walks phases 0 (address settles), 1 (memory samples), 2 (data consumed).
    assign w_rdy        = (r_ph == 2'd2);
    assign w_read_state = (r_state == c_LDW) || (r_state == c_HDR) || (r_state == c_FILL);
    assign w_kclamp     = (wmem_dut_read_data[3:0] > 4'(MAX_K)) ? 4'(MAX_K) : wmem_dut_read_data[3:0];
    assign w_hdr_ok     = (sram_dut_read_data >= 16'd3) && (sram_dut_read_data <= 16'(MAX_DIM));
    assign w_ldw_done   = (r_widx == 4'd0) ? (w_kclamp == 4'd0) : (r_widx == r_kcnt);
    assign w_last_row   = (r_out_row == r_n - 5'd3);
    assign w_more_k     = ({1'b0, r_kidx} + 4'd1) < r_kcnt;

    function automatic logic [3:0] f_popcnt(input logic [8:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 9; i++) s = s + {3'd0, v[i]};
        return s;
    endfunction

    always_comb begin
        w_kern = 9'd0;
        w_thr  = 4'd5;
        for (int i = 0; i < MAX_K; i++) begin
            if (r_kidx == 3'(i)) begin
                w_kern = r_kern[i];
`ifdef BNN_THRESH_EN
                w_thr  = r_thr[i];
`endif
            end
        end
    end

    for (genvar c = 0; c < MAX_DIM - 2; c++) begin : g_col
        logic [8:0] w_win;
        assign w_win    = {r_row2[c +: 3], r_row1[c +: 3], r_row0[c +: 3]};
        assign w_pix[c] = (f_popcnt(~(w_kern ^ w_win)) >= w_thr);
    end

    always_comb begin
        w_row_bits = 16'd0;
        for (int c = 0; c < MAX_DIM - 2; c++) begin
            w_row_bits[c] = w_pix[c] && (5'(c) <= r_n - 5'd3);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (dut_run) w_next = c_LDW;
            c_LDW:  if (w_rdy && w_ldw_done) w_next = c_HDR;
            c_HDR: begin
                if (w_rdy) begin
                    if (!w_hdr_ok)            w_next = c_IDLE;
                    else if (r_kcnt == 4'd0)  w_next = c_HDR;
                    else                      w_next = c_FILL;
                end
            end
            c_FILL: if (w_rdy && (r_nrows >= 5'd2)) w_next = c_OUT;
            c_OUT:  w_next = w_last_row ? c_NEXT : c_FILL;
            c_NEXT: w_next = w_more_k ? c_FILL : c_HDR;
            default: w_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dut_busy              = (r_state != c_IDLE);
        dut_sram_write_enable = (r_state == c_OUT);
        dut_sram_write_data   = (r_state == c_OUT) ? w_row_bits : 16'd0;
    end

    assign dut_sram_read_address  = r_saddr;
    assign dut_wmem_read_address  = r_waddr;
    assign dut_sram_write_address = r_oaddr;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ph       <= 2'd0;
            r_widx     <= 4'd0;
            r_kcnt     <= 4'd0;
            r_kidx     <= 3'd0;
            r_n        <= 5'd0;
            r_nrows    <= 5'd0;
            r_out_row  <= 5'd0;
            r_img_base <= 12'd0;
            r_saddr    <= 12'd0;
            r_waddr    <= 12'd0;
            r_oaddr    <= 12'd0;
            r_row0     <= '0;
            r_row1     <= '0;
            r_row2     <= '0;
            for (int i = 0; i < MAX_K; i++) begin
                r_kern[i] <= 9'd0;
`ifdef BNN_THRESH_EN
                r_thr[i]  <= 4'd0;
`endif
            end
        end else begin
            r_ph <= (w_read_state && !w_rdy) ? r_ph + 2'd1 : 2'd0;
            if (r_state == c_LDW)  r_waddr <= {8'd0, r_widx};
            if (r_state == c_HDR)  r_saddr <= r_img_base;
            if (r_state == c_FILL) r_saddr <= r_img_base + 12'(r_nrows) + 12'd1;

            case (r_state)
                c_IDLE: begin
                    if (dut_run) begin
                        r_widx     <= 4'd0;
                        r_kcnt     <= 4'd0;
                        r_img_base <= 12'd0;
                        r_oaddr    <= 12'd0;
                    end
                end
                c_LDW: begin
                    if (w_rdy) begin
                        if (r_widx == 4'd0) r_kcnt <= w_kclamp;
                        for (int i = 0; i < MAX_K; i++) begin
                            if (r_widx == 4'(i + 1)) begin
                                r_kern[i] <= wmem_dut_read_data[8:0];
`ifdef BNN_THRESH_EN
                                r_thr[i]  <= wmem_dut_read_data[12:9];
`endif
                            end
                        end
                        r_widx <= r_widx + 4'd1;
                    end
                end
                c_HDR: begin
                    if (w_rdy && w_hdr_ok) begin
                        r_n       <= sram_dut_read_data[4:0];
                        r_kidx    <= 3'd0;
                        r_nrows   <= 5'd0;
                        r_out_row <= 5'd0;
                        r_row0    <= '0;
                        r_row1    <= '0;
                        r_row2    <= '0;
                        // With no kernels the image is skipped straight to the next header.
                        if (r_kcnt == 4'd0)
                            r_img_base <= r_img_base + 12'(sram_dut_read_data[4:0]) + 12'd1;
                    end
                end
                c_FILL: begin
                    if (w_rdy) begin
                        r_row0  <= r_row1;
                        r_row1  <= r_row2;
                        r_row2  <= sram_dut_read_data[MAX_DIM-1:0];
                        r_nrows <= r_nrows + 5'd1;
                    end
                end
                c_OUT: begin
                    r_oaddr   <= r_oaddr + 12'd1;
                    r_out_row <= r_out_row + 5'd1;
                end
                c_NEXT: begin
                    if (w_more_k) begin
                        r_kidx    <= r_kidx + 3'd1;
                        r_nrows   <= 5'd0;
                        r_out_row <= 5'd0;
                        r_row0    <= '0;
                        r_row1    <= '0;
                        r_row2    <= '0;
                    end else begin
                        r_img_base <= r_img_base + 12'(r_n) + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
